decode_queue: RTL

Parametrised, registered RV32I(+M) decode stage between instruction fetch and register read. Accepts raw instructions with their PC over a valid/ready handshake and decodes them in the accept cycle. Decoded bundles are buffered in a DEPTH-entry FIFO and presented to the issue stage over a second valid/ready handshake. Adds what a purely combinational decode lacks: buffering, back-pressure, flush, illegal-instruction detection, optional M-extension decode and rd=x0 write suppression.

---
 rtl/decode_queue.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// decode_queue: RV32I(+M) decoder feeding a DEPTH-entry FIFO of decoded bundles.
// Instructions are decoded in the accept cycle; out_* come only from the head entry's registers.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter bit EN_M  = 1'b0,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [31:0]                out_imm,
  output logic [5:0]                 out_alu_code,
  output logic                       out_alu_src,
  output logic                       out_reg_write,
  output logic                       out_jal,
  output logic                       out_jalr,
  output logic                       out_branch,
  output logic [1:0]                 out_mem_store,
  output logic [2:0]                 out_mem_load,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;

  localparam logic [5:0] ALU_NOP = 6'd0, ALU_ADD = 6'd1, ALU_SUB = 6'd2, ALU_SLL = 6'd3;
  localparam logic [5:0] ALU_SLT = 6'd4, ALU_SLTU = 6'd5, ALU_XOR = 6'd6, ALU_SRL = 6'd7;
  localparam logic [5:0] ALU_SRA = 6'd8, ALU_OR = 6'd9, ALU_AND = 6'd10;
  localparam logic [5:0] ALU_BEQ = 6'd11, ALU_BNE = 6'd12, ALU_BLT = 6'd13, ALU_BGE = 6'd14;
  localparam logic [5:0] ALU_BLTU = 6'd15, ALU_BGEU = 6'd16;
  localparam logic [5:0] ALU_LB = 6'd17, ALU_LH = 6'd18, ALU_LW = 6'd19, ALU_LBU = 6'd20;
  localparam logic [5:0] ALU_LHU = 6'd21, ALU_SB = 6'd22, ALU_SH = 6'd23, ALU_SW = 6'd24;
  localparam logic [5:0] ALU_LUI = 6'd25, ALU_JAL = 6'd26, ALU_AUIPC = 6'd27, ALU_JALR = 6'd28;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [5:0]      alu_code;
    logic            alu_src;
    logic            reg_write;
    logic            jal;
    logic            jalr;
    logic            branch;
    logic [1:0]      mem_store;
    logic [2:0]      mem_load;
    logic            illegal;
  } bundle_t;

  // Shared by OP (funct7=0) and OPIMM; shifts get their arithmetic variant separately.
  function automatic logic [5:0] base_code(input logic [2:0] f3);
    case (f3)
      3'b000:  base_code = ALU_ADD;
      3'b001:  base_code = ALU_SLL;
      3'b010:  base_code = ALU_SLT;
      3'b011:  base_code = ALU_SLTU;
      3'b100:  base_code = ALU_XOR;
      3'b101:  base_code = ALU_SRL;
      3'b110:  base_code = ALU_OR;
      default: base_code = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal, writes;
  bundle_t     dec;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.rs1       = in_inst[19:15];
    dec.rs2       = in_inst[24:20];
    dec.rd        = in_inst[11:7];
    dec.mem_store = 2'b11;
    dec.mem_load  = 3'b111;
    dec.alu_src   = !(opcode == OPC_OP || opcode == OPC_BRANCH);
    illegal       = (in_inst[1:0] != 2'b11);
    writes        = 1'b0;
    case (opcode)
      OPC_LUI:   begin dec.alu_code = ALU_LUI;   dec.imm = imm_u; writes = 1'b1; end
      OPC_AUIPC: begin dec.alu_code = ALU_AUIPC; dec.imm = imm_u; writes = 1'b1; end
      OPC_JAL:   begin dec.alu_code = ALU_JAL; dec.imm = imm_j; dec.jal = 1'b1; writes = 1'b1; end
      OPC_JALR: begin
        dec.alu_code = ALU_JALR; dec.imm = imm_i; dec.jalr = 1'b1; writes = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.branch = 1'b1;
        case (funct3)
          3'b000:  dec.alu_code = ALU_BEQ;
          3'b001:  dec.alu_code = ALU_BNE;
          3'b100:  dec.alu_code = ALU_BLT;
          3'b101:  dec.alu_code = ALU_BGE;
          3'b110:  dec.alu_code = ALU_BLTU;
          3'b111:  dec.alu_code = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i; writes = 1'b1;
        case (funct3)
          3'b000:  begin dec.alu_code = ALU_LB;  dec.mem_load = 3'b000; end
          3'b001:  begin dec.alu_code = ALU_LH;  dec.mem_load = 3'b001; end
          3'b010:  begin dec.alu_code = ALU_LW;  dec.mem_load = 3'b010; end
          3'b100:  begin dec.alu_code = ALU_LBU; dec.mem_load = 3'b011; end
          3'b101:  begin dec.alu_code = ALU_LHU; dec.mem_load = 3'b100; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm = imm_s;
        case (funct3)
          3'b000:  begin dec.alu_code = ALU_SB; dec.mem_store = 2'b00; end
          3'b001:  begin dec.alu_code = ALU_SH; dec.mem_store = 2'b01; end
          3'b010:  begin dec.alu_code = ALU_SW; dec.mem_store = 2'b10; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.imm = imm_i; writes = 1'b1;
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
        else if (funct3 == 3'b101 && funct7 == 7'b0100000) dec.alu_code = ALU_SRA;
        else if (funct3 == 3'b101 && funct7 != 7'b0000000) illegal = 1'b1;
        else dec.alu_code = base_code(funct3);
      end
      OPC_OP: begin
        writes = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (EN_M) dec.alu_code = {3'b101, funct3};
          else illegal = 1'b1;
        end
        else if (funct7 == 7'b0000000) dec.alu_code = base_code(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.alu_code = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.alu_code = ALU_SRA;
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal bundle still flows through the queue but must have no side effects.
    if (illegal) begin
      dec.alu_code  = ALU_NOP;
      dec.imm       = '0;
      dec.jal       = 1'b0;
      dec.jalr      = 1'b0;
      dec.branch    = 1'b0;
      dec.mem_store = 2'b11;
      dec.mem_load  = 3'b111;
      writes        = 1'b0;
    end
    dec.illegal   = illegal;
    dec.reg_write = writes && (dec.rd != 5'd0);
  end

  // Transfers happen on an edge where valid && ready; flush suppresses both transfers.
  bundle_t       mem [DEPTH];
  bundle_t       head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign out_pc        = head.pc;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_imm       = head.imm;
  assign out_alu_code  = head.alu_code;
  assign out_alu_src   = head.alu_src;
  assign out_reg_write = head.reg_write;
  assign out_jal       = head.jal;
  assign out_jalr      = head.jalr;
  assign out_branch    = head.branch;
  assign out_mem_store = head.mem_store;
  assign out_mem_load  = head.mem_load;
  assign out_illegal   = head.illegal;
endmodule
